sram_port_arbiter: RTL
======================

// Module: sram_port_arbiter
// PURPOSE
//  Shares the single SRAM port between the output-queue write path (store_pkt, wr_0_*)
//  and the read path (remove_pkt, rd_0_*). One grant per cycle at most; round-robin on tie.
//  Registers the SRAM command and returns read data in order with a fixed latency.
// PARAMETERS
//  DATA_WIDTH        64   packet data width
//  CTRL_WIDTH        8    ctrl width (DATA_WIDTH/8); SRAM word = DATA_WIDTH+CTRL_WIDTH
//  SRAM_ADDR_WIDTH   13   SRAM word address width
//  SRAM_RD_LATENCY   2    cycles from sram_addr driven to sram_rd_data valid (1..4)
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high
//  wr_0_req       in   1       write request; held with addr/data until acked
//  wr_0_addr      in   13      write address
//  wr_0_data      in   72      write word {ctrl,data}
//  wr_0_ack       out  1       1-cycle pulse: write accepted this cycle
//  rd_0_req       in   1       read request; held with addr until acked
//  rd_0_addr      in   13      read address
//  rd_0_ack       out  1       1-cycle pulse: read accepted this cycle
//  rd_0_vld       out  1       rd_0_data valid
//  rd_0_data      out  72      read word {ctrl,data}
//  sram_req       out  1       SRAM command valid (registered)
//  sram_we        out  1       1=write, 0=read (registered)
//  sram_addr      out  13      SRAM address (registered)
//  sram_wr_data   out  72      SRAM write data (registered)
//  sram_rd_data   in   72      SRAM read data, SRAM_RD_LATENCY after sram_addr
// BEHAVIOUR
//  - Reset: all outputs 0; last_grant=READ (first tie goes to write); read-valid pipe flushed.
//  - Acks combinational from req + state; cmd registered: ack in cycle N -> sram_* in N+1.
//  - Grant rule per cycle: only wr req -> W; only rd req -> R; both -> side != last_grant.
//    last_grant updates only on an issued grant. Never wr_0_ack and rd_0_ack same cycle.
//  - No grant: sram_req=0, sram_we=0; sram_addr/sram_wr_data hold previous values.
//  - Write grant: sram_we=1, sram_addr=wr_0_addr, sram_wr_data=wr_0_data in N+1.
//  - Read grant: sram_we=0, sram_addr=rd_0_addr in N+1; data sampled at N+1+L into
//    rd_0_data, rd_0_vld=1 in N+2+L (L=SRAM_RD_LATENCY; default ack->vld = 4 cycles).
//  - Read tracking: (L+1)-deep valid shift register, no backpressure; one read per cycle,
//    results strictly in issue order; rd_0_vld is 1-cycle pulse per read.
//  - Requester may change addr/data in cycle after ack (store_pkt style); sampled at ack only.
//  - Req dropped before ack: no access, no ack (request withdrawn legally).
//  - Addresses passed unchanged; wrap-around is the requesters' responsibility.
//  - States: ST_ARB (normal), ST_TURN (only with macro below). Reset mid-operation:
//    in-flight reads discarded, no rd_0_vld for them after reset deasserts.
// CONFIGURATION
//  `SRAM_ARB_TURNAROUND_EN defined: any grant whose direction differs from the previous
//   issued access (R->W or W->R) is delayed one cycle: ST_ARB -> ST_TURN (no ack,
//   sram_req=0) -> ST_ARB grants. Same-direction back-to-back grants unaffected.
//   Tie arbitration unchanged (side chosen before the turnaround cycle is inserted).
//  Not defined: ST_TURN absent; direction switches back-to-back, full 1 access/cycle.
// TESTING
//  1 wr_0_req held, addrs 0x010..0x013 data 0xAA..AD, one word per ack -> wr_0_ack 4
//    consecutive cycles; sram_we=1, sram_addr 0x010..0x013 each one cycle after ack.
//  2 single read 0x020, model returns 72'h0FF_DEAD_BEEF at L=2 -> rd_0_vld exactly 4
//    cycles after rd_0_ack, rd_0_data=72'h0FF_DEAD_BEEF, no other vld pulses.
//  3 both reqs held 8 cycles after reset -> acks W,R,W,R,W,R,W,R; never both high.
//  4 8 back-to-back reads 0x100..0x107 -> 8 consecutive rd_0_vld, data in address order.
//  5 `SRAM_ARB_TURNAROUND_EN: read acked at N, write pending -> no ack at N+1,
//    wr_0_ack at N+2, sram_req=0 at N+2; without macro wr_0_ack at N+1.
//  6 2 reads in flight, reset pulsed 1 cycle -> rd_0_vld stays 0; all outputs 0 during reset.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: one SRAM port shared by wr_0 and rd_0, round-robin on tie.
// Define SRAM_ARB_TURNAROUND_EN to insert an idle cycle on each R/W switch.
module sram_port_arbiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int SRAM_ADDR_WIDTH = 13,
    parameter int SRAM_RD_LATENCY = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]          wr_0_addr,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]    wr_0_data,
    output logic                                wr_0_ack,
    input  logic                                rd_0_req,
    input  logic [SRAM_ADDR_WIDTH-1:0]          rd_0_addr,
    output logic                                rd_0_ack,
    output logic                                rd_0_vld,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0]    rd_0_data,
    output logic                                sram_req,
    output logic                                sram_we,
    output logic [SRAM_ADDR_WIDTH-1:0]          sram_addr,
    output logic [DATA_WIDTH+CTRL_WIDTH-1:0]    sram_wr_data,
    input  logic [DATA_WIDTH+CTRL_WIDTH-1:0]    sram_rd_data
);

    localparam int WW = DATA_WIDTH + CTRL_WIDTH;
    localparam int L  = SRAM_RD_LATENCY;

    logic                       r_last_wr;
    logic                       r_sram_req;
    logic                       r_sram_we;
    logic [SRAM_ADDR_WIDTH-1:0] r_sram_addr;
    logic [WW-1:0]              r_sram_wr_data;
    logic [L-1:0]               r_vpipe;
    logic                       r_rd_vld;
    logic [WW-1:0]              r_rd_data;

    logic                       w_pick_wr;
    logic                       w_pick_rd;
    logic                       w_gnt_wr;
    logic                       w_gnt_rd;
    logic                       w_cmd_rd;
    logic [L-1:0]               w_vpipe_nxt;

    // Tie goes to the side that did not win last time.
    assign w_pick_wr = wr_0_req & (~rd_0_req | ~r_last_wr);
    assign w_pick_rd = rd_0_req & ~w_pick_wr;

`ifdef SRAM_ARB_TURNAROUND_EN
    typedef enum logic {
        ST_ARB  = 1'b0,
        ST_TURN = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_any;
    logic   w_switch;

    assign w_switch = r_any &
                      ((w_pick_wr & ~r_last_wr) | (w_pick_rd & r_last_wr));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_ARB;
            r_any   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (wr_0_ack | rd_0_ack) begin
                r_any <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_wr    = 1'b0;
        w_gnt_rd    = 1'b0;
        unique case (r_state)
            ST_ARB: begin
                if (w_switch) begin
                    w_state_nxt = ST_TURN;
                end else begin
                    w_gnt_wr = w_pick_wr;
                    w_gnt_rd = w_pick_rd;
                end
            end
            ST_TURN: begin
                w_state_nxt = ST_ARB;
                w_gnt_wr    = w_pick_wr;
                w_gnt_rd    = w_pick_rd;
            end
        endcase
    end
`else
    assign w_gnt_wr = w_pick_wr;
    assign w_gnt_rd = w_pick_rd;
`endif

    assign wr_0_ack = w_gnt_wr & ~reset;
    assign rd_0_ack = w_gnt_rd & ~reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_wr      <= 1'b0;
            r_sram_req     <= 1'b0;
            r_sram_we      <= 1'b0;
            r_sram_addr    <= '0;
            r_sram_wr_data <= '0;
        end else begin
            r_sram_req <= wr_0_ack | rd_0_ack;
            r_sram_we  <= wr_0_ack;
            if (wr_0_ack) begin
                r_last_wr      <= 1'b1;
                r_sram_addr    <= wr_0_addr;
                r_sram_wr_data <= wr_0_data;
            end else if (rd_0_ack) begin
                r_last_wr   <= 1'b0;
                r_sram_addr <= rd_0_addr;
            end
        end
    end

    // One valid bit per read in flight; the tail marks the cycle data is on the bus.
    assign w_cmd_rd = r_sram_req & ~r_sram_we;

    if (L == 1) begin : g_pipe1
        assign w_vpipe_nxt = w_cmd_rd;
    end else begin : g_pipen
        assign w_vpipe_nxt = {r_vpipe[L-2:0], w_cmd_rd};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_vpipe   <= '0;
            r_rd_vld  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            r_vpipe  <= w_vpipe_nxt;
            r_rd_vld <= r_vpipe[L-1];
            if (r_vpipe[L-1]) begin
                r_rd_data <= sram_rd_data;
            end
        end
    end

    assign sram_req     = r_sram_req;
    assign sram_we      = r_sram_we;
    assign sram_addr    = r_sram_addr;
    assign sram_wr_data = r_sram_wr_data;
    assign rd_0_vld     = r_rd_vld;
    assign rd_0_data    = r_rd_data;

endmodule
